// File: rtl/stack_mem_ctrl_if.sv
// Bundles the command, response, status and stack-RAM signals of stack_mem_ctrl.
// The master side is the environment (CPU strobes, response consumer, RAM read data).
interface stack_mem_ctrl_if #(
    parameter int DATA_W = 8,
    parameter int AW     = 4
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [DATA_W-1:0] cmd_data;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              err_overflow;
    logic              err_underflow;
    logic [AW:0]       count;
    logic              empty;
    logic              full;
    logic              ram_we;
    logic              ram_re;
    logic [AW-1:0]     ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    modport master (
        output cmd_valid, cmd_op, cmd_data, rsp_ready, ram_rdata,
        input  cmd_ready, rsp_valid, rsp_data, err_overflow, err_underflow,
               count, empty, full, ram_we, ram_re, ram_addr, ram_wdata
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_data, rsp_ready, ram_rdata,
        output cmd_ready, rsp_valid, rsp_data, err_overflow, err_underflow,
               count, empty, full, ram_we, ram_re, ram_addr, ram_wdata
    );
endinterface

// File: rtl/stack_mem_ctrl.sv
// Stack sequencer for a single-port synchronous RAM: owns the stack pointer and
// turns PUSH/POP/TOS/CLEAR into RAM write/read sequences with a valid/ready response.
module stack_mem_ctrl #(
    parameter int DATA_W = 8,
    parameter int AW     = 4
) (
    input logic             clk,
    input logic             rst,
    stack_mem_ctrl_if.slave bus_io
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_WR   = 3'd1;
    localparam logic [2:0] S_RD   = 3'd2;
    localparam logic [2:0] S_RCAP = 3'd3;
    localparam logic [2:0] S_RESP = 3'd4;

    localparam logic [1:0] OP_PUSH  = 2'b00;
    localparam logic [1:0] OP_POP   = 2'b01;
    localparam logic [1:0] OP_TOS   = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    localparam logic [AW:0] DEPTH_C = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0] ONE_C   = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0] ZERO_C  = {(AW+1){1'b0}};

    logic [2:0]        state_q, state_d;
    logic [AW:0]       sp_q, sp_d;
    logic [DATA_W-1:0] wlatch_q, wlatch_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              is_pop_q, is_pop_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;

    logic              accept_s;
    logic              empty_s;
    logic              full_s;
    logic [AW:0]       sp_m1_s;

    assign accept_s = bus_io.cmd_valid && (state_q == S_IDLE);
    assign empty_s  = (sp_q == ZERO_C);
    assign full_s   = (sp_q == DEPTH_C);
    assign sp_m1_s  = sp_q - ONE_C;

    // Next-state, stack pointer and data-latch decode.
    always_comb begin
        state_d    = state_q;
        sp_d       = sp_q;
        wlatch_d   = wlatch_q;
        rsp_data_d = rsp_data_q;
        is_pop_d   = is_pop_q;
        ovf_d      = 1'b0;
        unf_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    case (bus_io.cmd_op)
                        OP_PUSH: begin
                            if (full_s) begin
                                ovf_d = 1'b1;
                            end else begin
                                wlatch_d = bus_io.cmd_data;
                                state_d  = S_WR;
                            end
                        end
                        OP_POP, OP_TOS: begin
                            if (empty_s) begin
                                unf_d = 1'b1;
                            end else begin
                                is_pop_d = (bus_io.cmd_op == OP_POP);
                                state_d  = S_RD;
                            end
                        end
                        OP_CLEAR: sp_d = ZERO_C;
                        default:  sp_d = sp_q;
                    endcase
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WR: begin
                sp_d    = sp_q + ONE_C;
                state_d = S_IDLE;
            end
            S_RD: begin
                // The pointer drops here so count already reflects the pop during RCAP.
                if (is_pop_q) begin
                    sp_d = sp_m1_s;
                end else begin
                    sp_d = sp_q;
                end
                state_d = S_RCAP;
            end
            S_RCAP: begin
                rsp_data_d = bus_io.ram_rdata;
                state_d    = S_RESP;
            end
            S_RESP: begin
                if (bus_io.rsp_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_RESP;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any in-flight op.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            sp_q       <= ZERO_C;
            wlatch_q   <= {DATA_W{1'b0}};
            rsp_data_q <= {DATA_W{1'b0}};
            is_pop_q   <= 1'b0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            sp_q       <= sp_d;
            wlatch_q   <= wlatch_d;
            rsp_data_q <= rsp_data_d;
            is_pop_q   <= is_pop_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
        end
    end

    // RAM strobes are Moore outputs of state and pointer, idle-zero elsewhere.
    always_comb begin
        bus_io.ram_we    = 1'b0;
        bus_io.ram_re    = 1'b0;
        bus_io.ram_addr  = {AW{1'b0}};
        bus_io.ram_wdata = {DATA_W{1'b0}};
        case (state_q)
            S_WR: begin
                bus_io.ram_we    = 1'b1;
                bus_io.ram_addr  = sp_q[AW-1:0];
                bus_io.ram_wdata = wlatch_q;
            end
            S_RD: begin
                bus_io.ram_re   = 1'b1;
                bus_io.ram_addr = sp_m1_s[AW-1:0];
            end
            default: begin
                bus_io.ram_we = 1'b0;
                bus_io.ram_re = 1'b0;
            end
        endcase
    end

    assign bus_io.cmd_ready     = (state_q == S_IDLE);
    assign bus_io.rsp_valid     = (state_q == S_RESP);
    assign bus_io.rsp_data      = rsp_data_q;
    assign bus_io.err_overflow  = ovf_q;
    assign bus_io.err_underflow = unf_q;
    assign bus_io.count         = sp_q;
    assign bus_io.empty         = empty_s;
    assign bus_io.full          = full_s;

endmodule

// File: tb/tb_stack_mem_ctrl.sv
// Bench for stack_mem_ctrl: directed scenarios plus random command mix, checked
// against a queue-based stack model and a behavioural synchronous RAM.
module tb_stack_mem_ctrl;
    localparam int DATA_W = 8;
    localparam int AW     = 4;
    localparam int DEPTH  = 16;

    logic clk;
    logic rst;
    int   errors;
    int   checks;
    int   model_q[$];
    logic [DATA_W-1:0] mem [DEPTH];

    stack_mem_ctrl_if #(.DATA_W(DATA_W), .AW(AW)) bus ();

    stack_mem_ctrl #(.DATA_W(DATA_W), .AW(AW)) u_dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous single-port RAM: read data appears the cycle after ram_re.
    always @(posedge clk) begin
        if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
        if (bus.ram_re) bus.ram_rdata <= mem[bus.ram_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_push(input logic [DATA_W-1:0] d);
        int n;
        n = model_q.size();
        check("push_ready", bus.cmd_ready, 1);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'b00;
        bus.cmd_data  = d;
        step();
        bus.cmd_valid = 1'b0;
        bus.cmd_data  = ~d;
        if (n == DEPTH) begin
            check("ovf_pulse", bus.err_overflow, 1);
            check("ovf_no_we", bus.ram_we, 0);
            check("ovf_ready", bus.cmd_ready, 1);
            check("ovf_count", bus.count, DEPTH);
            step();
            check("ovf_clear", bus.err_overflow, 0);
            check("ovf_full", bus.full, 1);
        end else begin
            check("wr_we", bus.ram_we, 1);
            check("wr_addr", bus.ram_addr, n);
            check("wr_data", bus.ram_wdata, d);
            check("wr_busy", bus.cmd_ready, 0);
            step();
            check("wr_done_ready", bus.cmd_ready, 1);
            check("wr_count", bus.count, n + 1);
            check("wr_full", bus.full, (n + 1 == DEPTH) ? 1 : 0);
            model_q.push_back(int'(d));
        end
    endtask

    task automatic do_read(input bit is_pop, input int hold);
        int n;
        int exp_d;
        n = model_q.size();
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = is_pop ? 2'b01 : 2'b10;
        bus.cmd_data  = 8'($urandom);
        step();
        bus.cmd_valid = 1'b0;
        if (n == 0) begin
            check("unf_pulse", bus.err_underflow, 1);
            check("unf_no_re", bus.ram_re, 0);
            check("unf_no_rsp", bus.rsp_valid, 0);
            check("unf_ready", bus.cmd_ready, 1);
            step();
            check("unf_clear", bus.err_underflow, 0);
            check("unf_no_rsp2", bus.rsp_valid, 0);
        end else begin
            exp_d = model_q[n-1];
            check("rd_re", bus.ram_re, 1);
            check("rd_we_low", bus.ram_we, 0);
            check("rd_addr", bus.ram_addr, n - 1);
            check("rd_busy", bus.cmd_ready, 0);
            step();
            check("rcap_count", bus.count, is_pop ? n - 1 : n);
            check("rcap_no_rsp", bus.rsp_valid, 0);
            step();
            check("rsp_valid", bus.rsp_valid, 1);
            check("rsp_data", bus.rsp_data, exp_d);
            for (int i = 0; i < hold; i++) begin
                step();
                check("hold_valid", bus.rsp_valid, 1);
                check("hold_data", bus.rsp_data, exp_d);
                check("hold_busy", bus.cmd_ready, 0);
            end
            bus.rsp_ready = 1'b1;
            step();
            bus.rsp_ready = 1'b0;
            check("rsp_done", bus.rsp_valid, 0);
            check("rsp_ready_back", bus.cmd_ready, 1);
            if (is_pop) void'(model_q.pop_back());
            check("post_empty", bus.empty, (model_q.size() == 0) ? 1 : 0);
        end
    endtask

    task automatic do_clear();
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'b11;
        step();
        bus.cmd_valid = 1'b0;
        model_q.delete();
        check("clr_count", bus.count, 0);
        check("clr_empty", bus.empty, 1);
        check("clr_ready", bus.cmd_ready, 1);
    endtask

    initial begin
        int op;
        errors = 0;
        checks = 0;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'b00;
        bus.cmd_data  = 8'h00;
        bus.rsp_ready = 1'b0;
        rst = 1'b1;
        #12;
        check("rst_ready", bus.cmd_ready, 1);
        check("rst_empty", bus.empty, 1);
        check("rst_full", bus.full, 0);
        check("rst_count", bus.count, 0);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_rsp_data", bus.rsp_data, 0);
        check("rst_we", bus.ram_we, 0);
        check("rst_re", bus.ram_re, 0);
        check("rst_ovf", bus.err_overflow, 0);
        check("rst_unf", bus.err_underflow, 0);
        rst = 1'b0;
        step();

        do_push(8'h11);
        do_push(8'h22);
        do_push(8'h33);
        do_read(1'b0, 0);
        do_read(1'b1, 0);
        do_read(1'b1, 0);
        do_read(1'b1, 0);
        check("drained_empty", bus.empty, 1);

        do_read(1'b1, 0);
        do_read(1'b0, 0);

        for (int i = 0; i < DEPTH; i++) do_push(8'(8'hA0 + i));
        do_push(8'h5A);
        do_clear();

        for (int i = 0; i < 5; i++) do_push(8'(8'h40 + i));
        do_read(1'b1, 5);
        do_push(8'h77);
        check("pre_clr_count", bus.count, 5);
        do_clear();

        do_push(8'hC3);
        do_push(8'h3C);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'b01;
        step();
        bus.cmd_valid = 1'b0;
        step();
        rst = 1'b1;
        #1;
        check("arst_count", bus.count, 0);
        check("arst_rsp_valid", bus.rsp_valid, 0);
        check("arst_ready", bus.cmd_ready, 1);
        check("arst_we", bus.ram_we, 0);
        model_q.delete();
        #3;
        rst = 1'b0;
        step();
        step();
        check("arst_settled", bus.rsp_valid, 0);

        for (int it = 0; it < 300; it++) begin
            op = int'($urandom_range(0, 9));
            if (op < 5) begin
                do_push(8'($urandom));
            end else if (op < 7) begin
                do_read(1'b1, int'($urandom_range(0, 3)));
            end else if (op < 9) begin
                do_read(1'b0, int'($urandom_range(0, 2)));
            end else if ($urandom_range(0, 3) == 0) begin
                do_clear();
            end else begin
                do_read(1'b1, 0);
            end
            check("rand_count", bus.count, model_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
